// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI4-Stream packet generator.
package axis_pkt_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD,
    GAP
  } state_e;

  localparam logic [63:0] HDR_WORD_0_DEFAULT = 64'hEFBEFECAFECAFECA;
  localparam logic [63:0] HDR_WORD_1_DEFAULT = 64'h00000008EFBEEFBE;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Round-robin successor, wrapping from the last channel back to 0.
  function automatic logic [3:0] next_rr(input logic [3:0] ptr, input int num_channels);
    return (int'(ptr) >= num_channels - 1) ? 4'd0 : ptr + 4'd1;
  endfunction

endpackage

// File: rtl/axis_pkt_gen_chan_demux.sv
// Fans the single registered beat out to one of NC stream ports and returns
// that port's TREADY. Inactive ports drive all-zero TDATA/TSTRB/TLAST.
module axis_pkt_gen_chan_demux #(
  parameter int DW = 64,
  parameter int NC = 5
) (
  input  logic [3:0]         chan,
  input  logic               valid,
  input  logic [DW-1:0]      data,
  input  logic               last,
  output logic [NC*DW-1:0]   m_tdata,
  output logic [NC*DW/8-1:0] m_tstrb,
  output logic [NC-1:0]      m_tvalid,
  output logic [NC-1:0]      m_tlast,
  input  logic [NC-1:0]      m_tready,
  output logic               ready
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    m_tdata  = '0;
    m_tstrb  = '0;
    m_tvalid = '0;
    m_tlast  = '0;
    ready    = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (chan == 4'(c)) begin
        ready = m_tready[c];
        if (valid) begin
          m_tdata[c*DW +: DW]       = data;
          m_tstrb[c*DW/8 +: DW/8]   = '1;
          m_tvalid[c]               = 1'b1;
          m_tlast[c]                = last;
        end
      end
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: two header words plus a counting payload,
// sent on a fixed or round-robin channel with a configurable inter-packet gap.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int          C_M_AXIS_DATA_WIDTH = 64,
  parameter int          NUM_CHANNELS        = 5,
  parameter int          CNT_WIDTH           = 8,
  parameter logic [63:0] HDR_WORD_0          = HDR_WORD_0_DEFAULT,
  parameter logic [63:0] HDR_WORD_1          = HDR_WORD_1_DEFAULT
) (
  input  logic                                           ACLK,
  input  logic                                           ARESETN,
  input  logic                                           cfg_enable,
  input  logic [CNT_WIDTH-1:0]                           cfg_payload_words,
  input  logic [CNT_WIDTH-1:0]                           cfg_gap_cycles,
  input  logic                                           cfg_mode,
  input  logic [3:0]                                     cfg_fixed_chan,
  output logic [NUM_CHANNELS*C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [NUM_CHANNELS*C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [NUM_CHANNELS-1:0]                        M_AXIS_TVALID,
  output logic [NUM_CHANNELS-1:0]                        M_AXIS_TLAST,
  input  logic [NUM_CHANNELS-1:0]                        M_AXIS_TREADY,
  output logic                                           busy,
  output logic [31:0]                                    pkt_count
);

  localparam int DW = C_M_AXIS_DATA_WIDTH;

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [DW-1:0]        data_q, data_d;
  logic [3:0]           chan_q, chan_d;
  logic [3:0]           rr_ptr_q, rr_ptr_d;
  logic                 mode_q, mode_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]          pkt_count_q, pkt_count_d;

  logic                 chan_ready, beat, gap_done, start;
  logic [3:0]           sel_chan;
  logic [CNT_WIDTH-1:0] words_eff;
  logic [DW-1:0]        hdr0_ext, hdr1_ext;

  function automatic logic [DW-1:0] pay_word(input logic [CNT_WIDTH-1:0] cnt);
    return {(DW/8){8'(cnt)}};
  endfunction

  always_comb begin
    hdr0_ext        = '0;
    hdr0_ext[63:0]  = HDR_WORD_0;
    hdr1_ext        = '0;
    hdr1_ext[63:0]  = HDR_WORD_1;
  end

  always_comb begin
    if (cfg_mode == MODE_RR)                       sel_chan = rr_ptr_q;
    else if (int'(cfg_fixed_chan) >= NUM_CHANNELS) sel_chan = 4'd0;
    else                                           sel_chan = cfg_fixed_chan;
  end

  assign words_eff = (cfg_payload_words == '0) ? CNT_WIDTH'(1) : cfg_payload_words;
  assign beat      = valid_q & chan_ready;
  assign gap_done  = (gap_q == '0) || (gap_cnt_q == gap_q - 1'b1);
  // Config is sampled only when leaving IDLE or finishing a gap.
  assign start     = cfg_enable && ((state_q == IDLE) || (state_q == GAP && gap_done));

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    chan_d      = chan_q;
    rr_ptr_d    = rr_ptr_q;
    mode_d      = mode_q;
    words_d     = words_q;
    gap_d       = gap_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_count_d = pkt_count_q;

    case (state_q)
      IDLE: ;
      HDR0: begin
        if (beat) begin
          state_d = HDR1;
          data_d  = hdr1_ext;
        end
      end
      HDR1: begin
        if (beat) begin
          state_d    = PAYLOAD;
          word_cnt_d = '0;
          data_d     = pay_word('0);
          last_d     = (words_q == CNT_WIDTH'(1));
        end
      end
      PAYLOAD: begin
        if (beat) begin
          if (last_q) begin
            state_d     = GAP;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            data_d      = '0;
            gap_cnt_d   = '0;
            pkt_count_d = pkt_count_q + 32'd1;
            if (mode_q == MODE_RR) rr_ptr_d = next_rr(rr_ptr_q, NUM_CHANNELS);
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            data_d     = pay_word(word_cnt_q + 1'b1);
            last_d     = ((word_cnt_q + 1'b1) == (words_q - 1'b1));
          end
        end
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
        else          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = HDR0;
      valid_d = 1'b1;
      last_d  = 1'b0;
      data_d  = hdr0_ext;
      chan_d  = sel_chan;
      mode_d  = cfg_mode;
      words_d = words_eff;
      gap_d   = cfg_gap_cycles;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      chan_q      <= '0;
      rr_ptr_q    <= '0;
      mode_q      <= MODE_FIXED;
      words_q     <= '0;
      gap_q       <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      pkt_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      rr_ptr_q    <= rr_ptr_d;
      mode_q      <= mode_d;
      words_q     <= words_d;
      gap_q       <= gap_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign pkt_count = pkt_count_q;

  axis_pkt_gen_chan_demux #(
    .DW (DW),
    .NC (NUM_CHANNELS)
  ) u_demux (
    .chan     (chan_q),
    .valid    (valid_q),
    .data     (data_q),
    .last     (last_q),
    .m_tdata  (M_AXIS_TDATA),
    .m_tstrb  (M_AXIS_TSTRB),
    .m_tvalid (M_AXIS_TVALID),
    .m_tlast  (M_AXIS_TLAST),
    .m_tready (M_AXIS_TREADY),
    .ready    (chan_ready)
  );

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: table of packet configurations plus
// hand-written backpressure, enable-drop and mid-packet reset sequences.
module tb_axis_pkt_gen;

  localparam int NC = 5;
  localparam int DW = 64;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              cfg_enable;
  logic [7:0]        cfg_payload_words;
  logic [7:0]        cfg_gap_cycles;
  logic              cfg_mode;
  logic [3:0]        cfg_fixed_chan;
  logic [NC*DW-1:0]  tdata;
  logic [NC*DW/8-1:0] tstrb;
  logic [NC-1:0]     tvalid;
  logic [NC-1:0]     tlast;
  logic [NC-1:0]     tready;
  logic              busy;
  logic [31:0]       pkt_count;

  axis_pkt_gen dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .cfg_enable        (cfg_enable),
    .cfg_payload_words (cfg_payload_words),
    .cfg_gap_cycles    (cfg_gap_cycles),
    .cfg_mode          (cfg_mode),
    .cfg_fixed_chan    (cfg_fixed_chan),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TSTRB      (tstrb),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TREADY     (tready),
    .busy              (busy),
    .pkt_count         (pkt_count)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit mode;
    int fixed_chan;
    int n_cfg;
    int g_cfg;
    int exp_chan;
    int exp_n;
    int exp_gap;
  } vec_t;

  vec_t vecs[10];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_pkts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] exp_word(input int i);
    logic [7:0] b;
    if (i == 0) return 64'hEFBEFECAFECAFECA;
    if (i == 1) return 64'h00000008EFBEEFBE;
    b = 8'(i - 2);
    return {8{b}};
  endfunction

  task automatic set_cfg(input bit mode, input int fc, input int n, input int g);
    cfg_mode          = mode;
    cfg_fixed_chan    = 4'(fc);
    cfg_payload_words = 8'(n);
    cfg_gap_cycles    = 8'(g);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    cfg_enable = 1'b0;
    ARESETN    = 1'b0;
    @(negedge ACLK);
    ARESETN    = 1'b1;
    @(negedge ACLK);
  endtask

  // Called at a negedge; returns at the first negedge after the TLAST beat
  // (or after a reset release when abort_at is reached).
  task automatic capture_pkt(input string tag, input int exp_chan, input int exp_n,
                             input bit bp, input int drop_at, input int abort_at);
    int ch;
    int w;
    int budget;
    budget = 0;
    while (tvalid == '0 && budget < 100) begin
      @(negedge ACLK);
      budget++;
    end
    check({tag, " tvalid seen"}, 64'(tvalid != '0), 64'd1);
    if (tvalid == '0) return;
    ch = 0;
    for (int c = 0; c < NC; c++) if (tvalid[c]) ch = c;
    check({tag, " channel"}, 64'(ch), 64'(exp_chan));
    w = 0;
    while (w < exp_n + 2 && budget < 3000) begin
      check({tag, " tvalid"}, 64'(tvalid), 64'(1) << ch);
      check({tag, " data"}, tdata[ch*DW +: 64], exp_word(w));
      check({tag, " tlast"}, 64'(tlast), 64'(w == exp_n + 1) << ch);
      check({tag, " tstrb"}, 64'(tstrb), 64'(8'hff) << (ch * 8));
      if (w == abort_at) begin
        #2 ARESETN = 1'b0;
        #1;
        check({tag, " rst tvalid"}, 64'(tvalid), 64'd0);
        check({tag, " rst tdata"}, 64'(tdata != '0), 64'd0);
        check({tag, " rst tlast"}, 64'(tlast), 64'd0);
        check({tag, " rst tstrb"}, 64'(tstrb), 64'd0);
        check({tag, " rst busy"}, 64'(busy), 64'd0);
        check({tag, " rst pkt_count"}, 64'(pkt_count), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tready  = '1;
        return;
      end
      if (w == drop_at) cfg_enable = 1'b0;
      tready = bp ? NC'($urandom) : '1;
      if (tready[ch]) w++;
      @(negedge ACLK);
      budget++;
    end
    check({tag, " complete"}, 64'(w), 64'(exp_n + 2));
    tready = '1;
  endtask

  // Called at the first negedge after a TLAST beat; counts idle cycles
  // until the next packet starts or the block returns to IDLE.
  task automatic measure_gap(input string tag, input int exp_gap);
    int n;
    n = 0;
    check({tag, " pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
    while (busy && tvalid == '0 && n < 300) begin
      n++;
      @(negedge ACLK);
    end
    check({tag, " gap cycles"}, 64'(n), 64'(exp_gap));
  endtask

  task automatic run_table(input int lo, input int hi);
    set_cfg(vecs[lo].mode, vecs[lo].fixed_chan, vecs[lo].n_cfg, vecs[lo].g_cfg);
    cfg_enable = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      capture_pkt($sformatf("v%0d", i), vecs[i].exp_chan, vecs[i].exp_n, 1'b0, -1, -1);
      exp_pkts++;
      if (i < hi) set_cfg(vecs[i+1].mode, vecs[i+1].fixed_chan, vecs[i+1].n_cfg, vecs[i+1].g_cfg);
      else        cfg_enable = 1'b0;
      measure_gap($sformatf("v%0d", i), vecs[i].exp_gap);
    end
  endtask

  initial begin
    ARESETN    = 1'b0;
    cfg_enable = 1'b0;
    set_cfg(1'b0, 0, 0, 0);
    tready     = '1;

    vecs[0] = '{1'b0, 0, 32, 3, 0, 32, 3};
    vecs[1] = '{1'b0, 9, 0, 0, 0, 1, 1};
    vecs[2] = '{1'b0, 3, 5, 1, 3, 5, 1};
    vecs[3] = '{1'b0, 4, 1, 2, 4, 1, 2};
    for (int i = 4; i < 10; i++) vecs[i] = '{1'b1, 0, 4, 1, (i - 4) % NC, 4, 1};

    repeat (3) @(negedge ACLK);
    check("reset tvalid", 64'(tvalid), 64'd0);
    check("reset tdata", 64'(tdata != '0), 64'd0);
    check("reset tstrb", 64'(tstrb), 64'd0);
    check("reset tlast", 64'(tlast), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset pkt_count", 64'(pkt_count), 64'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Fixed-mode vectors, including N=0, out-of-range channel and G=0.
    set_cfg(vecs[0].mode, vecs[0].fixed_chan, vecs[0].n_cfg, vecs[0].g_cfg);
    cfg_enable = 1'b1;
    @(negedge ACLK);
    check("first valid latency", 64'(tvalid), 64'd1);
    run_table(0, 3);
    check("idle after table busy", 64'(busy), 64'd0);

    // Round-robin: six packets over five channels.
    do_reset();
    exp_pkts = 0;
    run_table(4, 9);

    // Random backpressure.
    set_cfg(1'b0, 2, 6, 2);
    cfg_enable = 1'b1;
    capture_pkt("bp", 2, 6, 1'b1, -1, -1);
    exp_pkts++;
    cfg_enable = 1'b0;
    measure_gap("bp", 2);

    // Enable dropped at payload word 2 must not truncate the packet.
    set_cfg(1'b0, 1, 8, 1);
    cfg_enable = 1'b1;
    capture_pkt("drop", 1, 8, 1'b0, 4, -1);
    exp_pkts++;
    measure_gap("drop", 1);
    check("drop busy", 64'(busy), 64'd0);
    check("drop tvalid", 64'(tvalid), 64'd0);

    // Reset during payload word 5 of the second round-robin packet.
    do_reset();
    exp_pkts = 0;
    set_cfg(1'b1, 0, 10, 1);
    cfg_enable = 1'b1;
    capture_pkt("rr0", 0, 10, 1'b0, -1, -1);
    exp_pkts++;
    measure_gap("rr0", 1);
    capture_pkt("abort", 1, 10, 1'b0, -1, 7);
    exp_pkts = 0;
    @(negedge ACLK);
    check("restart valid on ch0", 64'(tvalid), 64'd1);
    capture_pkt("restart", 0, 10, 1'b0, -1, -1);
    exp_pkts++;
    cfg_enable = 1'b0;
    measure_gap("restart", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
